// File: rtl/rr_mux_arb.sv
// N-channel, WIDTH-bit registered mux with valid/ready on every channel and on the output.
// Supports round-robin arbitration (mode 0) or explicit channel select (mode 1).
module rr_mux_arb #(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned N     = 8,
    localparam int unsigned SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    // One extra bit so ptr+k cannot overflow before the modulo-N fold.
    localparam int unsigned     IDXW  = SELW + 1;
    localparam logic [IDXW-1:0] N_IDX = IDXW'(N);
    localparam logic [SELW-1:0] LAST  = SELW'(N - 1);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic [WIDTH-1:0] chan_data [N];
    logic [IDXW-1:0]  rr_idx;
    logic [SELW-1:0]  rr_grant;
    logic             rr_hit;
    logic             sel_hit;
    logic [SELW-1:0]  grant_idx;
    logic             grant_vld;
    logic             load_en;
    logic             xfer;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Round-robin search starting at ptr, wrapping at N (N need not be a power of two).
    always_comb begin
        rr_hit   = 1'b0;
        rr_grant = '0;
        rr_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            rr_idx = {1'b0, ptr_q} + IDXW'(k);
            if (rr_idx >= N_IDX) begin
                rr_idx = rr_idx - N_IDX;
            end
            if (!rr_hit && in_valid[rr_idx[SELW-1:0]]) begin
                rr_hit   = 1'b1;
                rr_grant = rr_idx[SELW-1:0];
            end
        end
    end

    // Out-of-range select indices never grant.
    always_comb begin
        sel_hit = 1'b0;
        if ({1'b0, sel} < N_IDX) begin
            sel_hit = in_valid[sel];
        end
    end

    assign grant_vld = mode ? sel_hit : rr_hit;
    assign grant_idx = mode ? sel     : rr_grant;
    assign load_en   = !out_valid_q || out_ready;
    assign xfer      = load_en && grant_vld && !rst;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state for the output stage and the arbitration pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = chan_data[grant_idx];
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            if (!mode) begin
                ptr_d = (grant_idx == LAST) ? '0 : grant_idx + SELW'(1);
            end
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule
